// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: run-control sequencer for the 3BC core.
// Turns the Start level into PC load/enable pulses, picks the ROM start
// address of the next program, watches Halt, drives Ack, counts executed
// cycles and stops runaway programs with a cycle-limit watchdog.
module prog_run_ctrl #(
  parameter int                 PC_W       = 10,
  parameter int                 CNT_W      = 16,
  parameter int                 NUM_PROGS  = 3,
  parameter logic [PC_W-1:0]    PROG0_BASE = PC_W'(0),
  parameter logic [PC_W-1:0]    PROG1_BASE = PC_W'(256),
  parameter logic [PC_W-1:0]    PROG2_BASE = PC_W'(512),
  parameter logic [PC_W-1:0]    PROG3_BASE = PC_W'(768),
  parameter logic [CNT_W-1:0]   TIMEOUT    = CNT_W'(16'hFFF0)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Halt,
  output logic              PcLoad,
  output logic [PC_W-1:0]   PcLoadAddr,
  output logic              PcEn,
  output logic              Ack,
  output logic [1:0]        ProgIdx,
  output logic [CNT_W-1:0]  CycleCt,
  output logic              Timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic [1:0]       LAST_IDX   = 2'(NUM_PROGS - 1);
  localparam logic [CNT_W-1:0] LIMIT_M1   = TIMEOUT - CNT_W'(1);

  state_e             state_q, state_d;
  logic [1:0]         prog_idx_q, prog_idx_d;
  logic [CNT_W-1:0]   cycle_ct_q, cycle_ct_d;
  logic               timeout_q, timeout_d;
  logic               first_run_q, first_run_d;
  logic               pc_load_q, pc_load_d;
  logic               pc_en_q, pc_en_d;
  logic               ack_q, ack_d;

  // Next-state, counter and registered-output decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    prog_idx_d  = prog_idx_q;
    cycle_ct_d  = cycle_ct_q;
    timeout_d   = timeout_q;
    first_run_d = first_run_q;

    case (state_q)
      IDLE, DONE: begin
        // Arming clears the run statistics; the very first run after reset
        // uses program 0, every later run advances to the next program.
        if (Start) begin
          state_d     = ARM;
          cycle_ct_d  = '0;
          timeout_d   = 1'b0;
          first_run_d = 1'b0;
          if (!first_run_q) begin
            prog_idx_d = (prog_idx_q == LAST_IDX) ? 2'd0 : prog_idx_q + 2'd1;
          end
        end
      end

      ARM: begin
        // Launch on the first edge that sees Start released.
        if (!Start) begin
          state_d = RUN;
        end
      end

      RUN: begin
        // Halt has priority over the watchdog on the same edge.
        if (Halt) begin
          state_d = DONE;
        end else if (cycle_ct_q == LIMIT_M1) begin
          state_d    = DONE;
          cycle_ct_d = TIMEOUT;
          timeout_d  = 1'b1;
        end else begin
          cycle_ct_d = cycle_ct_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Control outputs are registered copies of the state being entered.
    pc_load_d = (state_d == ARM);
    pc_en_d   = (state_d == RUN);
    ack_d     = (state_d == DONE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      prog_idx_q  <= 2'd0;
      cycle_ct_q  <= '0;
      timeout_q   <= 1'b0;
      first_run_q <= 1'b1;
      pc_load_q   <= 1'b0;
      pc_en_q     <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q     <= state_d;
      prog_idx_q  <= prog_idx_d;
      cycle_ct_q  <= cycle_ct_d;
      timeout_q   <= timeout_d;
      first_run_q <= first_run_d;
      pc_load_q   <= pc_load_d;
      pc_en_q     <= pc_en_d;
      ack_q       <= ack_d;
    end
  end

  // Start address of the selected program, decoded straight from ProgIdx.
  always_comb begin
    PcLoadAddr = PROG0_BASE;
    case (prog_idx_q)
      2'd1:    PcLoadAddr = PROG1_BASE;
      2'd2:    PcLoadAddr = PROG2_BASE;
      2'd3:    PcLoadAddr = PROG3_BASE;
      default: PcLoadAddr = PROG0_BASE;
    endcase
  end

  assign PcLoad  = pc_load_q;
  assign PcEn    = pc_en_q;
  assign Ack     = ack_q;
  assign ProgIdx = prog_idx_q;
  assign CycleCt = cycle_ct_q;
  assign Timeout = timeout_q;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Testbench for prog_run_ctrl: directed and randomized runs. Each launched
// run pushes its expected result (program index, load address, cycle count,
// timeout flag) into a scoreboard; a monitor pops and compares it when Ack
// rises. Phase checks (reset, arm, launch, abort) are made inline.
module tb_prog_run_ctrl;

  localparam int PC_W      = 10;
  localparam int CNT_W     = 16;
  localparam int NUM_PROGS = 3;
  localparam int TIMEOUT   = 24;

  typedef struct {
    int idx;
    int addr;
    int cyc;
    int to;
  } exp_t;

  logic              Clk;
  logic              Reset;
  logic              Start;
  logic              Halt;
  logic              PcLoad;
  logic [PC_W-1:0]   PcLoadAddr;
  logic              PcEn;
  logic              Ack;
  logic [1:0]        ProgIdx;
  logic [CNT_W-1:0]  CycleCt;
  logic              Timeout;

  int   n_cmp = 0;
  int   n_err = 0;
  int   model_runs = 0;
  exp_t sb[$];
  int   bases[4] = '{0, 256, 512, 768};

  prog_run_ctrl #(
    .PC_W      (PC_W),
    .CNT_W     (CNT_W),
    .NUM_PROGS (NUM_PROGS),
    .TIMEOUT   (16'(TIMEOUT))
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Halt       (Halt),
    .PcLoad     (PcLoad),
    .PcLoadAddr (PcLoadAddr),
    .PcEn       (PcEn),
    .Ack        (Ack),
    .ProgIdx    (ProgIdx),
    .CycleCt    (CycleCt),
    .Timeout    (Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a run halted when its count reaches halt_at (below the limit)
  // reports halt_at cycles; otherwise the watchdog reports TIMEOUT and flags it.
  // Programs are taken round-robin starting from 0 after every reset.
  function automatic exp_t predict(input int run_no, input int halt_at);
    exp_t e;
    e.idx  = run_no % NUM_PROGS;
    e.addr = bases[e.idx];
    if (halt_at < TIMEOUT) begin
      e.cyc = halt_at;
      e.to  = 0;
    end else begin
      e.cyc = TIMEOUT;
      e.to  = 1;
    end
    return e;
  endfunction

  // Monitor: compare the completed run each time Ack rises.
  initial begin
    logic ack_prev;
    exp_t e;
    ack_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (Ack && !ack_prev) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected_ack: got Ack=1, expected no completed run (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("done_prog_idx", 32'(ProgIdx), e.idx);
          check("done_addr", 32'(PcLoadAddr), e.addr);
          check("done_cycle_ct", 32'(CycleCt), e.cyc);
          check("done_timeout", 32'(Timeout), e.to);
        end
      end
      ack_prev = Ack;
    end
  end

  // One complete run. halt_at >= TIMEOUT means Halt is never raised;
  // abort_at >= 0 pulls reset low mid-run once the count reaches it.
  task automatic do_run(input int arm_cycles, input int halt_at, input bit noise,
                        input int abort_at, input int linger);
    exp_t e;
    bit   done;
    e = predict(model_runs, halt_at);
    model_runs++;
    if (abort_at < 0) sb.push_back(e);

    @(negedge Clk);
    Start = 1'b1;
    for (int i = 0; i < arm_cycles; i++) begin
      @(negedge Clk);
      check("arm_pc_load", 32'(PcLoad), 1);
      check("arm_addr", 32'(PcLoadAddr), e.addr);
      check("arm_pc_en", 32'(PcEn), 0);
      check("arm_ack", 32'(Ack), 0);
      check("arm_cycle_ct", 32'(CycleCt), 0);
    end
    Start = 1'b0;
    @(negedge Clk);
    check("launch_pc_en", 32'(PcEn), 1);
    check("launch_pc_load", 32'(PcLoad), 0);
    check("launch_cycle_ct", 32'(CycleCt), 0);

    done = 1'b0;
    for (int c = 0; c <= TIMEOUT + 4 && !done; c++) begin
      if (c == abort_at) begin
        check("abort_cycle_ct_before", 32'(CycleCt), c);
        Halt  = 1'b0;
        Start = 1'b1;
        #2 Reset = 1'b0;
        #1;
        check("abort_cycle_ct", 32'(CycleCt), 0);
        check("abort_prog_idx", 32'(ProgIdx), 0);
        check("abort_pc_en", 32'(PcEn), 0);
        check("abort_pc_load", 32'(PcLoad), 0);
        check("abort_ack", 32'(Ack), 0);
        check("abort_timeout", 32'(Timeout), 0);
        Start = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        model_runs = 0;
        return;
      end
      Halt  = (c == halt_at);
      Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge Clk);
      if (Ack) done = 1'b1;
      else check("run_pc_en", 32'(PcEn), 1);
    end
    Halt  = 1'b0;
    Start = 1'b0;
    if (!done) begin
      check("run_ack_bound", 32'(Ack), 1);
    end else begin
      check("done_pc_en", 32'(PcEn), 0);
      for (int i = 0; i < linger; i++) begin
        @(negedge Clk);
        check("linger_ack", 32'(Ack), 1);
        check("linger_cycle_ct", 32'(CycleCt), e.cyc);
        check("linger_timeout", 32'(Timeout), e.to);
      end
    end
  endtask

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("FAIL global_time_limit: got no end of test, expected finish before limit");
    $fatal(1, "time limit");
  end

  initial begin
    Reset = 1'b0;
    Start = 1'b1;
    Halt  = 1'b1;
    #1;
    check("rst_pc_load", 32'(PcLoad), 0);
    check("rst_pc_en", 32'(PcEn), 0);
    check("rst_ack", 32'(Ack), 0);
    check("rst_prog_idx", 32'(ProgIdx), 0);
    check("rst_cycle_ct", 32'(CycleCt), 0);
    check("rst_timeout", 32'(Timeout), 0);
    check("rst_addr", 32'(PcLoadAddr), 0);
    repeat (2) @(negedge Clk);
    check("rst_hold_pc_load", 32'(PcLoad), 0);
    Start = 1'b0;
    Halt  = 1'b0;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check("idle_ack", 32'(Ack), 0);
    check("idle_pc_load", 32'(PcLoad), 0);
    check("idle_pc_en", 32'(PcEn), 0);

    // Directed: 3-cycle arm, halt at 20, then round-robin through programs.
    do_run(3, 20, 1'b0, -1, 2);
    do_run(1, 5, 1'b0, -1, 0);
    do_run(2, 7, 1'b0, -1, 1);
    do_run(1, 3, 1'b0, -1, 0);
    // Watchdog, then a normal run clears the flag, then halt at the limit.
    do_run(1, TIMEOUT + 10, 1'b0, -1, 1);
    do_run(1, 5, 1'b0, -1, 0);
    do_run(1, TIMEOUT - 1, 1'b0, -1, 1);
    do_run(1, 0, 1'b0, -1, 0);
    // Start noise in RUN, then reset mid-run at count 7.
    do_run(2, 12, 1'b1, -1, 0);
    do_run(1, 15, 1'b1, 7, 0);
    do_run(1, 4, 1'b0, -1, 0);

    // Randomized runs.
    for (int r = 0; r < 40; r++) begin
      do_run(int'($urandom_range(1, 4)), int'($urandom_range(0, TIMEOUT + 3)),
             1'($urandom_range(0, 1)), -1, int'($urandom_range(0, 2)));
    end

    repeat (3) @(negedge Clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
